// File: rtl/uart_pkt_sched.sv
// uart_pkt_sched: turns one-cycle event requests into short UART packets.
// Four request classes (warn > light > coord > time) are latched as pending
// flags and served one packet at a time, byte by byte, through a handshake
// with an external UART transmitter (tx_start / tx_busy / tx_done).
// Build option: define UART_PKT_CHECKSUM_EN to append an XOR checksum byte
// to every packet.
module uart_pkt_sched (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [9:0] x_min,
  input  logic [9:0] x_max,
  input  logic [9:0] y_min,
  input  logic [9:0] y_max,
  input  logic [4:0] red_left_time,
  input  logic [4:0] green_left_time,
  input  logic       traffic_light,
  input  logic       traffic_amount,
  input  logic       human_violation,
  input  logic       car_violation,
  input  logic       tx_busy,
  input  logic       tx_done,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic [3:0] pending,
  output logic       sched_busy,
  output logic       ovr
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_t;

  state_t          state_q, state_d;
  logic [3:0]      pending_q, pending_d, pending_clr;
  logic [1:0]      cls_q, cls_d, prio;
  logic [6:0][7:0] pkt_q, pkt_d, build;
  logic [2:0]      len_q, len_d, idx_q, idx_d, build_len;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            ovr_q, ovr_d, sched_busy_q, sched_busy_d;
  logic [39:0]     coord;

  assign coord = {x_min, x_max, y_min, y_max};

  // Fixed-priority pick among pending classes: warn(3) > light(2) > coord(1) > time(0)
  always_comb begin
    prio = 2'd0;
    if (pending_q[3])      prio = 2'd3;
    else if (pending_q[2]) prio = 2'd2;
    else if (pending_q[1]) prio = 2'd1;
  end

  // Assemble the packet for the granted class; slot 0 goes out first and
  // unused slots stay zero so an XOR over all slots equals the packet XOR
  always_comb begin
    build     = '0;
    build_len = 3'd2;
    case (cls_q)
      2'd3: begin
        build[0] = 8'hA1;
        build[1] = {6'b0, human_violation, car_violation};
      end
      2'd2: begin
        build[0] = 8'hA2;
        build[1] = {6'b0, traffic_amount, traffic_light};
      end
      2'd1: begin
        build[0]  = 8'hA3;
        build[1]  = coord[39:32];
        build[2]  = coord[31:24];
        build[3]  = coord[23:16];
        build[4]  = coord[15:8];
        build[5]  = coord[7:0];
        build_len = 3'd6;
      end
      default: begin
        build[0]  = 8'hA4;
        build[1]  = {3'b0, red_left_time};
        build[2]  = {3'b0, green_left_time};
        build_len = 3'd3;
      end
    endcase
`ifdef UART_PKT_CHECKSUM_EN
    build[build_len] = build[0] ^ build[1] ^ build[2] ^ build[3] ^
                       build[4] ^ build[5] ^ build[6];
    build_len        = build_len + 3'd1;
`endif
  end

  // Scheduler next state: pending bookkeeping and the IDLE/LOAD/SEND/WAIT walk
  always_comb begin
    state_d     = state_q;
    pending_clr = '0;
    cls_d       = cls_q;
    pkt_d       = pkt_q;
    len_d       = len_q;
    idx_d       = idx_q;
    tx_data_d   = tx_data_q;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          state_d     = LOAD;
          cls_d       = prio;
          pending_clr = 4'b0001 << prio;
        end
      end
      LOAD: begin
        // Snapshot now so later input changes cannot corrupt the packet
        pkt_d     = build;
        len_d     = build_len;
        idx_d     = 3'd0;
        tx_data_d = build[0];
        state_d   = SEND;
      end
      SEND: begin
        if (!tx_busy) state_d = WAIT;
      end
      WAIT: begin
        if (tx_done) begin
          if (({1'b0, idx_q} + 4'd1) < {1'b0, len_q}) begin
            idx_d     = idx_q + 3'd1;
            tx_data_d = pkt_q[idx_q + 3'd1];
            state_d   = SEND;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A new request in the same cycle as the grant re-arms the class
    pending_d    = (pending_q & ~pending_clr) | req;
    ovr_d        = |(req & pending_q);
    sched_busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      cls_q        <= 2'd0;
      pkt_q        <= '0;
      len_q        <= 3'd0;
      idx_q        <= 3'd0;
      tx_data_q    <= 8'h00;
      ovr_q        <= 1'b0;
      sched_busy_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      cls_q        <= cls_d;
      pkt_q        <= pkt_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      tx_data_q    <= tx_data_d;
      ovr_q        <= ovr_d;
      sched_busy_q <= sched_busy_d;
    end
  end

  // Launch is qualified by the live busy flag so the pulse never overlaps busy
  assign tx_start   = (state_q == SEND) && !tx_busy;
  assign tx_data    = tx_data_q;
  assign pending    = pending_q;
  assign sched_busy = sched_busy_q;
  assign ovr        = ovr_q;

endmodule

// File: tb/tb_uart_pkt_sched.sv
// Bench for uart_pkt_sched: a byte scoreboard fed by the stimulus and drained
// by a monitor on every tx_start, plus a simple UART transmitter responder.
module tb_uart_pkt_sched;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [9:0] x_min, x_max, y_min, y_max;
  logic [4:0] red_left_time, green_left_time;
  logic       traffic_light, traffic_amount, human_violation, car_violation;
  logic       tx_busy, tx_done;
  logic       tx_busy_m, tx_busy_f, tx_done_m, tx_done_f;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [3:0] pending;
  logic       sched_busy, ovr;

  int         n_cmp = 0, n_bad = 0, n_start = 0, n_ovr = 0;
  logic [7:0] exp_q[$];

  assign tx_busy = tx_busy_m | tx_busy_f;
  assign tx_done = tx_done_m | tx_done_f;

  always #5 clk = ~clk;

  uart_pkt_sched dut (
    .clk(clk), .reset(reset), .req(req),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
    .red_left_time(red_left_time), .green_left_time(green_left_time),
    .traffic_light(traffic_light), .traffic_amount(traffic_amount),
    .human_violation(human_violation), .car_violation(car_violation),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_start(tx_start), .tx_data(tx_data),
    .pending(pending), .sched_busy(sched_busy), .ovr(ovr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected bytes of one packet; checksum byte appended in the checksum build
  task automatic push_pkt(input logic [6:0][7:0] b, input int n);
    logic [7:0] cs;
    cs = 8'h00;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(b[i]);
      cs = cs ^ b[i];
    end
`ifdef UART_PKT_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!sched_busy && pending == 4'h0 && exp_q.size() == 0) return;
    end
    chk({name, "_timeout"}, exp_q.size(), 0);
  endtask

  task automatic wait_pend(input logic [3:0] e);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (pending == e) break;
    end
    chk("pend_order", pending, e);
  endtask

  // Monitor: every launched byte is compared against the scoreboard head
  always @(negedge clk) begin
    if (!reset && tx_start) begin
      n_start++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL tx_unexpected: got %02h expected none", tx_data);
      end else begin
        chk("tx_byte", tx_data, exp_q.pop_front());
      end
    end
    if (ovr) n_ovr++;
  end

  // UART responder: busy for three cycles after a launch, then a done pulse
  initial begin
    tx_busy_m = 1'b0;
    tx_done_m = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && tx_start) begin
        @(posedge clk); #1 tx_busy_m = 1'b1;
        repeat (3) @(negedge clk);
        tx_busy_m = 1'b0;
        tx_done_m = 1'b1;
        @(posedge clk); #1 tx_done_m = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0][7:0] b;
    int base, base_ovr;
    reset = 1'b1; req = 4'h0; tx_busy_f = 1'b0; tx_done_f = 1'b0;
    x_min = '0; x_max = '0; y_min = '0; y_max = '0;
    red_left_time = '0; green_left_time = '0;
    traffic_light = 0; traffic_amount = 0; human_violation = 0; car_violation = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_pending", pending, 0);
    chk("rst_busy", sched_busy, 0);
    chk("rst_ovr", ovr, 0);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);

    // time packet and request-to-launch latency
    red_left_time = 5'd5; green_left_time = 5'd12;
    b = '0; b[0] = 8'hA4; b[1] = 8'h05; b[2] = 8'h0C; push_pkt(b, 3);
    req = 4'b0001;
    @(posedge clk); #1 chk("lat_pending_c1", pending, 4'b0001);
    chk("lat_start_c1", tx_start, 0);
    @(negedge clk) req = 4'h0;
    @(posedge clk); #1 chk("lat_load_c2", sched_busy, 1);
    chk("lat_pend_clr_c2", pending, 0);
    chk("lat_start_c2", tx_start, 0);
    @(posedge clk); #1 chk("lat_start_c3", tx_start, 1);
    wait_idle("time");

    // all four classes at once, strict priority order
    human_violation = 1; car_violation = 0; traffic_amount = 1; traffic_light = 1;
    x_min = 10'h001; x_max = 10'h002; y_min = 10'h003; y_max = 10'h004;
    b = '0; b[0] = 8'hA1; b[1] = 8'h02; push_pkt(b, 2);
    b = '0; b[0] = 8'hA2; b[1] = 8'h03; push_pkt(b, 2);
    b = '0; b[0] = 8'hA3; b[1] = 8'h00; b[2] = 8'h40; b[3] = 8'h20; b[4] = 8'h0C; b[5] = 8'h04;
    push_pkt(b, 6);
    b = '0; b[0] = 8'hA4; b[1] = 8'h05; b[2] = 8'h0C; push_pkt(b, 3);
    @(negedge clk) req = 4'b1111;
    @(posedge clk); #1 chk("all_pending", pending, 4'b1111);
    @(negedge clk) req = 4'h0;
    wait_pend(4'b0111);
    wait_pend(4'b0011);
    wait_pend(4'b0001);
    wait_pend(4'b0000);
    wait_idle("all4");

    // coord bit packing; inputs change once the packet is snapshotted
    x_min = 10'h3FF; x_max = 10'h000; y_min = 10'h155; y_max = 10'h2AA;
    b = '0; b[0] = 8'hA3; b[1] = 8'hFF; b[2] = 8'hC0; b[3] = 8'h05; b[4] = 8'h56; b[5] = 8'hAA;
    push_pkt(b, 6);
    @(negedge clk) req = 4'b0010;
    @(negedge clk) req = 4'h0;
    @(posedge clk);
    @(posedge clk); #1 x_min = 10'h000; y_max = 10'h000;
    wait_idle("coord");

    // overrun: second light request while light is still pending
    traffic_amount = 1; traffic_light = 1;
    base_ovr = n_ovr;
    b = '0; b[0] = 8'hA4; b[1] = 8'h05; b[2] = 8'h0C; push_pkt(b, 3);
    b = '0; b[0] = 8'hA2; b[1] = 8'h03; push_pkt(b, 2);
    @(negedge clk) req = 4'b0001;
    @(negedge clk) req = 4'h0;
    @(negedge clk);
    @(negedge clk) req = 4'b0100;
    @(negedge clk) req = 4'b0100;
    chk("ovr_light_pend", pending[2], 1);
    @(posedge clk); #1 chk("ovr_pulse", ovr, 1);
    @(negedge clk) req = 4'h0;
    @(posedge clk); #1 chk("ovr_one_cycle", ovr, 0);
    wait_idle("ovr");
    chk("ovr_count", n_ovr - base_ovr, 1);

    // transmitter held busy at SEND; stray done there must be ignored
    @(negedge clk) tx_busy_f = 1'b1;
    b = '0; b[0] = 8'hA4; b[1] = 8'h05; b[2] = 8'h0C; push_pkt(b, 3);
    req = 4'b0001;
    @(negedge clk) req = 4'h0;
    base = n_start;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tx_done_f = (i == 10);
    end
    tx_done_f = 1'b0;
    chk("busy_no_start", n_start - base, 0);
    chk("busy_held", sched_busy, 1);
    @(posedge clk); #1 tx_busy_f = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_one_start", n_start - base, 1);
    wait_idle("busy");

    // reset while waiting on byte 2 of a coord packet
    x_min = 10'h001; x_max = 10'h002; y_min = 10'h003; y_max = 10'h004;
    b = '0; b[0] = 8'hA3; b[1] = 8'h00; b[2] = 8'h40; b[3] = 8'h20; b[4] = 8'h0C; b[5] = 8'h04;
    push_pkt(b, 6);
    base = n_start;
    @(negedge clk) req = 4'b0010;
    @(negedge clk) req = 4'h0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (n_start - base >= 2) break;
    end
    chk("abort_reached_b2", n_start - base, 2);
    reset = 1'b1;
    #1;
    chk("abort_tx_start", tx_start, 0);
    chk("abort_tx_data", tx_data, 8'h00);
    chk("abort_pending", pending, 0);
    chk("abort_busy", sched_busy, 0);
    chk("abort_ovr", ovr, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    base = n_start;
    repeat (60) @(negedge clk);
    chk("abort_no_start", n_start - base, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
